// File: rtl/ConvAcc_pkg.sv
// Shared types and parameter defaults for the convolution accelerator buffers.
package ConvAcc_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_ADDR_W    = 14;
    localparam int unsigned DEF_NUM_BANKS = 2;

    // Ownership of one ping-pong bank: host filling, filled and waiting, or held by the EPU.
    typedef enum logic [1:0] {
        BankHost,
        BankFull,
        BankEpu
    } bank_state_e;

    // Round-robin successor of a bank index.
    function automatic int unsigned next_bank(int unsigned idx, int unsigned num_banks);
        return (idx + 1 >= num_banks) ? 32'd0 : idx + 1;
    endfunction

endpackage

// File: rtl/buf_bank_sram.sv
// Single-port word SRAM for one buffer bank; 1-cycle read latency, contents never reset.
module buf_bank_sram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [Depth];

    // Write commits at the request edge; a read registers the addressed word.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/banked_buf_wrapper.sv
// Ping-pong banked buffer between a host port and an EPU port with per-bank ownership.
module banked_buf_wrapper
    import ConvAcc_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
    localparam int unsigned BANK_W   = $clog2(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb_i,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [BANK_W-1:0] host_bank_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    input  logic              host_done_i,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_err_o,
    input  logic              epu_cs_i,
    input  logic              epu_we_i,
    input  logic [ADDR_W-1:0] epu_addr_i,
    input  logic [DATA_W-1:0] epu_wdata_i,
    input  logic              epu_done_i,
    output logic              epu_ready_o,
    output logic [BANK_W-1:0] epu_bank_o,
    output logic              epu_rvalid_o,
    output logic [DATA_W-1:0] epu_rdata_o
);

    bank_state_e       state_q [NUM_BANKS];
    logic [BANK_W-1:0] epu_bank_q;
    logic              epu_ready_q;
    logic              host_err_q;
    logic              host_rvalid_q;
    logic [BANK_W-1:0] host_rbank_q;
    logic              epu_rvalid_q;
    logic [BANK_W-1:0] epu_rbank_q;

    logic host_tgt_host, epu_tgt_full, any_epu;
    logic host_acc, done_acc, epu_acc, epu_rel, promote;

    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

    // Decode bank ownership and which requests are accepted this cycle.
    always_comb begin
        host_tgt_host = 1'b0;
        epu_tgt_full  = 1'b0;
        any_epu       = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (state_q[i] == BankEpu) any_epu = 1'b1;
            if (host_bank_i == BANK_W'(i) && state_q[i] == BankHost) host_tgt_host = 1'b1;
            if (epu_bank_q == BANK_W'(i) && state_q[i] == BankFull) epu_tgt_full = 1'b1;
        end
        // Out-of-range host bank indices never match and are therefore rejected.
        host_acc = ~rst & enb_i & host_req_i & host_tgt_host;
        done_acc = ~rst & enb_i & host_done_i & host_tgt_host;
        epu_acc  = ~rst & enb_i & epu_cs_i & epu_ready_q;
        epu_rel  = enb_i & epu_done_i & epu_ready_q;
        // A bank released this cycle blocks promotion until the next cycle.
        promote  = enb_i & epu_tgt_full & ~any_epu & ~epu_rel;
    end

    // Bank ownership state machine, EPU bank pointer and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) state_q[i] <= BankHost;
            epu_bank_q    <= '0;
            epu_ready_q   <= 1'b0;
            host_err_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rbank_q  <= '0;
            epu_rvalid_q  <= 1'b0;
            epu_rbank_q   <= '0;
        end else begin
            host_err_q    <= (host_req_i & ~host_acc) | (host_done_i & ~done_acc);
            host_rvalid_q <= host_acc & ~host_we_i;
            epu_rvalid_q  <= epu_acc & ~epu_we_i;
            if (host_acc) host_rbank_q <= host_bank_i;
            if (epu_acc) epu_rbank_q <= epu_bank_q;
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (done_acc && host_bank_i == BANK_W'(i)) begin
                    state_q[i] <= BankFull;
                end else if (epu_rel && epu_bank_q == BANK_W'(i)) begin
                    state_q[i] <= BankHost;
                end else if (promote && epu_bank_q == BANK_W'(i)) begin
                    state_q[i] <= BankEpu;
                end
            end
            if (epu_rel) begin
                epu_bank_q  <= BANK_W'(next_bank(32'(epu_bank_q), NUM_BANKS));
                epu_ready_q <= 1'b0;
            end else if (promote) begin
                epu_ready_q <= 1'b1;
            end
        end
    end

    // Host and EPU always target different banks, so each bank sees at most one port.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic host_sel, epu_sel;
        assign host_sel = host_acc && host_bank_i == BANK_W'(b);
        assign epu_sel  = epu_acc && epu_bank_q == BANK_W'(b);

        buf_bank_sram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_sram (
            .clk     (clk),
            .en_i    (host_sel | epu_sel),
            .we_i    (host_sel ? host_we_i : epu_we_i),
            .addr_i  (host_sel ? host_addr_i : epu_addr_i),
            .wdata_i (host_sel ? host_wdata_i : epu_wdata_i),
            .rdata_o (bank_rdata[b])
        );
    end

    // Steer read data from the bank that was read; force zero when no response is valid.
    always_comb begin
        host_rdata_o = '0;
        epu_rdata_o  = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (host_rvalid_q && host_rbank_q == BANK_W'(i)) host_rdata_o = bank_rdata[i];
            if (epu_rvalid_q && epu_rbank_q == BANK_W'(i)) epu_rdata_o = bank_rdata[i];
        end
    end

    assign host_rvalid_o = host_rvalid_q;
    assign host_err_o    = host_err_q;
    assign epu_ready_o   = epu_ready_q;
    assign epu_bank_o    = epu_bank_q;
    assign epu_rvalid_o  = epu_rvalid_q;

endmodule

// File: doc/banked_buf_wrapper.md
BANKED_BUF_WRAPPER -- requirements
Module: banked_buf_wrapper

Interface
REQ-001 Parameter DATA_W, default 32, buffer word width in bits.
REQ-002 Parameter ADDR_W, default 14, per-bank word address width; bank depth is 2**ADDR_W words.
REQ-003 Parameter NUM_BANKS, default 2, number of ping-pong banks; legal range 2..8.
REQ-004 Port clk  in  1  single clock; all logic is rising-edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port enb_i  in  1  block enable; when low, no accesses are accepted and no bank state changes.
REQ-007 Port host_req_i  in  1  host (AXI-side) access request, one word per cycle.
REQ-008 Port host_we_i  in  1  1 = write, 0 = read.
REQ-009 Port host_bank_i  in  $clog2(NUM_BANKS)  target bank.
REQ-010 Port host_addr_i  in  ADDR_W  word address.
REQ-011 Port host_wdata_i  in  DATA_W  write data.
REQ-012 Port host_done_i  in  1  host declares bank host_bank_i filled.
REQ-013 Port host_rvalid_o  out  1  host read data valid.
REQ-014 Port host_rdata_o  out  DATA_W  host read data.
REQ-015 Port host_err_o  out  1  one-cycle pulse for a rejected host access or done.
REQ-016 Port epu_cs_i, epu_we_i  in  1 each  EPU chip select and write enable.
REQ-017 Port epu_addr_i  in  ADDR_W; epu_wdata_i  in  DATA_W.
REQ-018 Port epu_done_i  in  1  EPU releases its current bank.
REQ-019 Port epu_ready_o  out  1  a bank is owned by the EPU.
REQ-020 Port epu_bank_o  out  $clog2(NUM_BANKS)  index of the bank the EPU owns or waits on.
REQ-021 Port epu_rvalid_o  out  1; epu_rdata_o  out  DATA_W.

Function
REQ-030 Each bank SHALL hold state HOST, FULL or EPU; bank SRAM read latency is 1 cycle.
REQ-031 HOST->FULL SHALL occur on host_done_i & enb_i with host_bank_i in HOST; otherwise host_err_o pulses on the next cycle.
REQ-032 FULL->EPU SHALL occur when bank epu_bank_o is FULL, no bank is EPU and enb_i is high; epu_ready_o rises the next cycle.
REQ-033 EPU->HOST SHALL occur on epu_done_i & epu_ready_o & enb_i; epu_bank_o increments modulo NUM_BANKS in the same edge.
REQ-034 A bank SHALL NOT be promoted in the same cycle as an epu_done_i release; earliest promotion is the following cycle.
REQ-035 A host access SHALL be accepted only when enb_i is high and the target bank is HOST; a rejected access does not touch SRAM and pulses host_err_o one cycle later.
REQ-036 An accepted host read SHALL assert host_rvalid_o with data exactly 1 cycle later; a write commits at the request edge.
REQ-037 An EPU access SHALL be accepted only when epu_cs_i & epu_ready_o & enb_i; it is routed to bank epu_bank_o; reads return with epu_rvalid_o 1 cycle later.
REQ-038 Host and EPU accesses to different banks SHALL proceed in the same cycle without stall.
REQ-039 host_rdata_o and epu_rdata_o SHALL be 0 whenever the corresponding rvalid is low.
REQ-040 host_done_i and epu_done_i asserted in the same cycle SHALL both take effect.

Reset
REQ-050 On rst, all banks SHALL go to HOST, epu_bank_o to 0, and every output to 0; pending read responses are dropped.
REQ-051 SRAM contents SHALL NOT be cleared by reset.

Structure
REQ-060 The bank-state enum and the DATA_W/ADDR_W/NUM_BANKS defaults SHALL live in a shared package, ConvAcc_pkg.
REQ-061 Each bank SHALL be an instance of one sub-module, buf_bank_sram (single-port, 1-cycle read), generated NUM_BANKS times.

Verification
REQ-070 Reset, then host write 0xA5A5_0001 to bank0 addr 3, read it back -> host_rvalid_o 1 cycle later, data 0xA5A5_0001.
REQ-071 host_done_i on bank0 -> epu_ready_o=1 two cycles later, epu_bank_o=0; EPU read addr 3 -> 0xA5A5_0001 after 1 cycle.
REQ-072 While EPU owns bank0, host writes bank0 -> host_err_o pulse, bank0 addr 3 unchanged; concurrent host write to bank1 succeeds.
REQ-073 Fill bank1, epu_done_i on bank0 -> bank0 HOST, epu_bank_o=1, epu_ready_o low one cycle then high.
REQ-074 NUM_BANKS=4, release bank3 -> epu_bank_o wraps to 0; with bank0 HOST, epu_ready_o stays 0.
REQ-075 Assert rst mid-read while EPU owns bank1 -> next cycle all outputs 0, no rvalid, all banks HOST.
